// File: rtl/quad_pkg.sv
// Shared phase type, direction constants and transition decode for quad_pos_decoder.
package quad_pkg;

  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} phase_t;
  typedef enum logic [1:0] {DEC_NONE, DEC_UP, DEC_DN, DEC_ERR} dec_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Position along the up sequence: S00->0, S01->1, S11->2, S10->3 (Gray to binary).
  function automatic logic [1:0] phase_pos(input phase_t p);
    logic [1:0] w_p;
    w_p = p;
    return {w_p[1], w_p[1] ^ w_p[0]};
  endfunction

  function automatic dec_t quad_decode(input phase_t old_p, input phase_t new_p);
    logic [1:0] w_d;
    dec_t       w_r;
    w_d = phase_pos(new_p) - phase_pos(old_p);
    case (w_d)
      2'd1:    w_r = DEC_UP;
      2'd3:    w_r = DEC_DN;
      2'd2:    w_r = DEC_ERR;
      default: w_r = DEC_NONE;
    endcase
    return w_r;
  endfunction

endpackage

// File: rtl/quad_in_filter.sv
// One encoder channel: 2-FF synchroniser followed by a run-length filter that
// accepts a new level only after FILT consecutive differing samples.
module quad_in_filter #(
  parameter int FILT = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_d};
      // A matching sample anywhere in the run throws the run away.
      if (r_sync[1] == r_acc) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT - 1)) begin
        r_acc <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_q = r_acc;

endmodule

// File: rtl/quad_pos_decoder.sv
// Quadrature A/B decoder with N-bit position counter (clear/load/enable).
// Optional index input z and idx pulse under `define QUAD_INDEX_EN.
module quad_pos_decoder
  import quad_pkg::*;
#(
  parameter int N    = 5,
  parameter int FILT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
`ifdef QUAD_INDEX_EN
  input  logic         z,
  output logic         idx,
`endif
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         dir,
  output logic         step,
  output logic         err
);

  logic         w_fa, w_fb, w_zrise, w_hold;
  phase_t       w_new, r_phase;
  dec_t         w_dec;
  logic         r_valid;
  logic [N-1:0] r_q, w_q_nxt;
  logic         r_dir, w_dir_nxt, r_step, w_step_nxt, r_err, w_err_nxt;

  quad_in_filter #(.FILT(FILT)) u_fa (.i_clk(clk), .i_rst(rst), .i_d(a), .o_q(w_fa));
  quad_in_filter #(.FILT(FILT)) u_fb (.i_clk(clk), .i_rst(rst), .i_d(b), .o_q(w_fb));

`ifdef QUAD_INDEX_EN
  logic w_fz, r_z_prev, r_idx;

  quad_in_filter #(.FILT(FILT)) u_fz (.i_clk(clk), .i_rst(rst), .i_d(z), .o_q(w_fz));

  assign w_zrise = w_fz & ~r_z_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z_prev <= 1'b0;
      r_idx    <= 1'b0;
    end else begin
      r_z_prev <= w_fz;
      r_idx    <= w_zrise;
    end
  end

  assign idx = r_idx;
`else
  assign w_zrise = 1'b0;
`endif

  assign w_new  = phase_t'({w_fa, w_fb});
  assign w_dec  = quad_decode(r_phase, w_new);
  assign w_hold = syn_clr | load | ~en | w_zrise;

  always_comb begin
    w_q_nxt    = r_q;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    // The first cycle after reset only captures the phase; nothing is decoded.
    if (r_valid) begin
      case (w_dec)
        DEC_UP: begin
          w_dir_nxt = DIR_UP;
          if (!w_hold) begin
            w_q_nxt    = r_q + N'(1);
            w_step_nxt = 1'b1;
          end
        end
        DEC_DN: begin
          w_dir_nxt = DIR_DN;
          if (!w_hold) begin
            w_q_nxt    = r_q - N'(1);
            w_step_nxt = 1'b1;
          end
        end
        DEC_ERR: w_err_nxt = 1'b1;
        default: ;
      endcase
    end
    if (w_zrise) w_q_nxt = '0;
    if (load)    w_q_nxt = d;
    if (syn_clr) w_q_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= S00;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_dir   <= DIR_UP;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_phase <= w_new;
      r_valid <= 1'b1;
      r_q     <= w_q_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign q    = r_q;
  assign dir  = r_dir;
  assign step = r_step;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_pos_decoder.sv
// Bench for quad_pos_decoder: vector table, hand sequences, and a random walk
// checked against a cycle-level reference model.
module tb_quad_pos_decoder;

  localparam int N    = 5;
  localparam int FILT = 3;
  localparam int MOD  = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         a = 1'b0, b = 1'b0, syn_clr = 1'b0, load = 1'b0, en = 1'b1;
  logic [N-1:0] d = '0;
  logic [N-1:0] q;
  logic         dir, step, err;
`ifdef QUAD_INDEX_EN
  logic         z = 1'b0;
  logic         idx;
`endif

  quad_pos_decoder #(.N(N), .FILT(FILT)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
`ifdef QUAD_INDEX_EN
    .z(z), .idx(idx),
`endif
    .syn_clr(syn_clr), .load(load), .en(en), .d(d),
    .q(q), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_s, cnt_e, cnt_i;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at negedge, then run h clocks counting pulses.
  task automatic seg(input bit ia, input bit ib, input bit clr, input bit ld,
                     input bit ena, input int dd, input int h);
    @(negedge clk);
    a = ia; b = ib; syn_clr = clr; load = ld; en = ena; d = N'(dd);
    cnt_s = 0; cnt_e = 0; cnt_i = 0;
    repeat (h) begin
      @(posedge clk); #1;
      cnt_s += int'(step);
      cnt_e += int'(err);
`ifdef QUAD_INDEX_EN
      cnt_i += int'(idx);
`endif
    end
  endtask

  typedef struct {
    bit a, b, clr, ld, en;
    int d, hold;
    int q;
    bit dir;
    int ns, ne;
  } vec_t;

  function automatic vec_t mk(input bit ia, input bit ib, input bit clr, input bit ld,
                              input bit ena, input int dd, input int h, input int eq,
                              input bit edir, input int ns, input int ne);
    vec_t v;
    v.a = ia; v.b = ib; v.clr = clr; v.ld = ld; v.en = ena; v.d = dd; v.hold = h;
    v.q = eq; v.dir = edir; v.ns = ns; v.ne = ne;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int unsigned m_q;
  bit          m_dir, m_valid, e_step, e_err;
  bit [1:0]    m_ph, m_acc;
  bit [1:0]    rq[$];   // raw {a,b} in the two synchroniser stages, oldest first
  bit [1:0]    sq[$];   // last FILT synchronised samples seen by the filters

  function automatic int pos_of(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] gray_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_q = 0; m_dir = 1'b1; m_valid = 1'b0; m_ph = 2'b00; m_acc = 2'b00;
    rq.delete(); rq.push_back(2'b00); rq.push_back(2'b00);
    sq.delete();
    for (int i = 0; i < FILT; i++) sq.push_back(2'b00);
  endtask

  task automatic model_edge(input bit ia, input bit ib, input bit clr, input bit ld,
                            input bit ena, input int dd);
    int       delta;
    bit [1:0] nacc;
    bit       all_diff;
    e_step = 1'b0; e_err = 1'b0;
    if (!m_valid) m_valid = 1'b1;
    else if (m_acc != m_ph) begin
      delta = (pos_of(m_acc) - pos_of(m_ph) + 4) % 4;
      if (delta == 2) e_err = 1'b1;
      else begin
        m_dir = (delta == 1);
        if (ena && !clr && !ld) begin
          m_q = (delta == 1) ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
          e_step = 1'b1;
        end
      end
    end
    m_ph = m_acc;
    if (clr) m_q = 0;
    else if (ld) m_q = dd % MOD;
    sq.push_back(rq[0]);
    if (sq.size() > FILT) void'(sq.pop_front());
    nacc = m_acc;
    for (int c = 0; c < 2; c++) begin
      all_diff = 1'b1;
      foreach (sq[i]) if (sq[i][c] == m_acc[c]) all_diff = 1'b0;
      if (all_diff) nacc[c] = ~m_acc[c];
    end
    m_acc = nacc;
    rq.push_back({ia, ib});
    void'(rq.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[22];

  initial begin
    int lat, p, hold, ex, ac;
    bit [1:0] ab;

    tbl[0]  = mk(0,0,0,0,1, 0, 8,  0,1,0,0);
    tbl[1]  = mk(0,1,0,0,1, 0, 8,  1,1,1,0);
    tbl[2]  = mk(1,1,0,0,1, 0, 8,  2,1,1,0);
    tbl[3]  = mk(1,0,0,0,1, 0, 8,  3,1,1,0);
    tbl[4]  = mk(0,0,0,0,1, 0, 8,  4,1,1,0);
    tbl[5]  = mk(0,0,1,0,1, 0, 2,  0,1,0,0);
    tbl[6]  = mk(1,0,0,0,1, 0, 8, 31,0,1,0);
    tbl[7]  = mk(0,0,0,0,1, 0, 8,  0,1,1,0);
    tbl[8]  = mk(1,0,0,0,1, 0, 2,  0,1,0,0);
    tbl[9]  = mk(0,0,0,0,1, 0, 8,  0,1,0,0);
    tbl[10] = mk(1,0,0,0,1, 0, 3,  0,1,0,0);
    tbl[11] = mk(0,0,0,0,1, 0,12,  0,1,2,0);
    tbl[12] = mk(1,1,0,0,1, 0, 8,  0,1,0,1);
    tbl[13] = mk(1,0,0,0,1, 0, 8,  1,1,1,0);
    tbl[14] = mk(0,0,0,0,0, 0, 8,  1,1,0,0);
    tbl[15] = mk(0,1,0,0,0, 0, 8,  1,1,0,0);
    tbl[16] = mk(1,1,0,0,0, 0, 8,  1,1,0,0);
    tbl[17] = mk(1,0,0,0,1, 0, 8,  2,1,1,0);
    tbl[18] = mk(0,0,0,1,1,20, 8, 20,1,0,0);
    tbl[19] = mk(0,0,1,1,1, 9, 3,  0,1,0,0);
    tbl[20] = mk(0,0,0,1,1, 7, 2,  7,1,0,0);
    tbl[21] = mk(1,0,0,0,1, 0, 8,  6,0,1,0);

    // Reset values while reset is held with the clock running.
    repeat (3) @(posedge clk);
    #1;
    chk("reset q", int'(q), 0);
    chk("reset dir", int'(dir), 1);
    chk("reset step/err", int'({step, err}), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      seg(tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].ld, tbl[i].en, tbl[i].d, tbl[i].hold);
      chk($sformatf("vec%0d q", i), int'(q), tbl[i].q);
      chk($sformatf("vec%0d dir", i), int'(dir), int'(tbl[i].dir));
      chk($sformatf("vec%0d steps", i), cnt_s, tbl[i].ns);
      chk($sformatf("vec%0d errs", i), cnt_e, tbl[i].ne);
    end

    // Asynchronous reset mid-operation (q=6, dir=0 before it).
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst q", int'(q), 0);
    chk("async rst dir", int'(dir), 1);
    chk("async rst step/err", int'({step, err}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: edge index (first capturing edge = 1) at which step appears.
    seg(0,0,0,0,1, 0, 10);
    @(negedge clk);
    b = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (step) lat = n;
    end
    chk("step latency edges", lat, FILT + 3);
    chk("latency q", int'(q), 1);
    seg(0,1,0,0,1, 0, 8);

`ifdef QUAD_INDEX_EN
    seg(0,1,0,1,1,17, 2);
    chk("idx preload q", int'(q), 17);
    @(negedge clk); z = 1'b1;
    seg(0,1,0,0,1, 0, 8);
    chk("idx clear q", int'(q), 0);
    chk("idx pulses", cnt_i, 1);
    @(negedge clk); z = 1'b0;
    seg(0,1,0,0,1, 0, 8);
    @(negedge clk); z = 1'b1;
    seg(0,1,0,1,1, 9, 8);
    chk("idx vs load q", int'(q), 9);
    @(negedge clk); z = 1'b0;
    seg(0,1,0,0,1, 0, 8);
`endif

    // Random walk against the model.
    @(negedge clk);
    rst = 1'b1; a = 1'b0; b = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    p = 0; hold = 0;
    for (int t = 0; t < 600; t++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: p = p + 1;
          5, 6, 7, 8:    p = p + 3;
          default:       p = p + 2;
        endcase
        hold = $urandom_range(1, 8);
      end
      hold--;
      ab = gray_of(p);
      a = ab[1]; b = ab[0];
      syn_clr = ($urandom_range(0, 39) == 0);
      load    = ($urandom_range(0, 29) == 0);
      en      = ($urandom_range(0, 9) != 0);
      d       = N'($urandom);
      model_edge(a, b, syn_clr, load, en, int'(d));
      @(posedge clk); #1;
      ex = int'({m_q[N-1:0], m_dir, e_step, e_err});
      ac = int'({q, dir, step, err});
      chk($sformatf("rand t=%0d {q,dir,step,err}", t), ac, ex);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
